dmem_responder: RTL and testbench

- Data-memory responder for the core's load/store port (`ram_ce`/`ram_we`/`ram_sel`/`ram_addr`/write data), i.e. the memory end of the core's data interface.
- Holds a word-organised RAM and services one request at a time with a configurable wait-state count.
- Returns read data with a one-cycle ready pulse and flags out-of-range or misaligned accesses.
- Sits in `soc_top` between `u_core_top` and the data address space, alongside `u_rom`.

---
 rtl/soc_defs.sv | 19 +
 rtl/dmem_bytewrite_ram.sv | 49 ++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_defs.sv
// Shared SoC definitions: data-memory responder state encoding, default data-space
// base address and byte-lane width.
package soc_defs;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0000_0000;
  localparam int          BYTE_W            = 8;

  // Word accesses only: any nonzero byte offset is rejected.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bytewrite_ram.sv
// DEPTH x 32 word array with per-lane write enables and a registered read port.
// The read register can be cleared so rejected and store responses return zero.
module dmem_bytewrite_ram
  import soc_defs::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic          rd_clr,
  output logic [31:0]   rdata
);

  logic [31:0] ram_mem [DEPTH];
  logic [31:0] rdata_r;

  // Lane-masked array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          ram_mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read register: cleared on reset or on request, otherwise holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_clr) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_en) begin
      rdata_r <= ram_mem[idx];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: captures one request,
// waits WAIT_CYCLES, commits to the array and pulses ram_ready for one cycle.
module dmem_responder
  import soc_defs::*;
#(
  parameter int          DEPTH       = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_ce,
  input  logic        ram_we,
  input  logic [3:0]  ram_sel,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_wdata,
  output logic [31:0] ram_rdata,
  output logic        ram_ready,
  output logic        ram_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  dmem_state_e state_r, state_nxt_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [3:0]  sel_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        ready_r;
  logic        err_r;

  logic        acc_we_s;
  logic [3:0]  acc_sel_s;
  logic [31:0] acc_addr_s;
  logic [31:0] acc_wdata_s;
  logic [31:0] off_s;
  logic        err_s;
  logic        commit_s;

  // With zero wait states the commit edge is the capture edge, so use live inputs in IDLE.
  always_comb begin
    acc_we_s    = we_r;
    acc_sel_s   = sel_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    if (state_r == DMEM_IDLE) begin
      acc_we_s    = ram_we;
      acc_sel_s   = ram_sel;
      acc_addr_s  = ram_addr;
      acc_wdata_s = ram_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_sel_s   = sel_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Offset high bits catch addresses past the array without forming BASE+size (no overflow).
  assign off_s = acc_addr_s - BASE_ADDR;
  assign err_s = addr_misaligned(acc_addr_s) ||
                 (acc_addr_s < BASE_ADDR) ||
                 (off_s[31:AW+2] != {(30-AW){1'b0}});

  // Next-state logic; a commit happens exactly on the edge that enters RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DMEM_IDLE: begin
        if (ram_ce) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s = DMEM_RESP;
          end else begin
            state_nxt_s = DMEM_WAIT;
          end
        end else begin
          state_nxt_s = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = DMEM_RESP;
        end else begin
          state_nxt_s = DMEM_WAIT;
        end
      end
      DMEM_RESP: state_nxt_s = DMEM_IDLE;
      default:   state_nxt_s = DMEM_IDLE;
    endcase
    commit_s = !rst && (state_nxt_s == DMEM_RESP);
  end

  // State, wait counter, request capture and response flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DMEM_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'h0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= commit_s;
      err_r   <= commit_s && err_s;
      if ((state_r == DMEM_IDLE) && ram_ce) begin
        we_r    <= ram_we;
        sel_r   <= ram_sel;
        addr_r  <= ram_addr;
        wdata_r <= ram_wdata;
        if (WAIT_CYCLES != 0) begin
          cnt_r <= WAIT_L - 4'd1;
        end
      end else if ((state_r == DMEM_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  dmem_bytewrite_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (commit_s && acc_we_s && !err_s),
    .be     (acc_sel_s),
    .idx    (off_s[AW+1:2]),
    .wdata  (acc_wdata_s),
    .rd_en  (commit_s && !acc_we_s && !err_s),
    .rd_clr (commit_s && (acc_we_s || err_s)),
    .rdata  (ram_rdata)
  );

  assign ram_ready = ready_r;
  assign ram_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: three responders (different wait states and bases)
// checked against an array-based memory model.
module tb_dmem_responder;

  localparam int DEPTH = 2048;
  localparam int ND    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce    [ND];
  logic        we    [ND];
  logic [3:0]  sel   [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic [31:0] rdata [ND];
  logic        ready [ND];
  logic        err   [ND];

  logic [31:0] mem_m [ND][DEPTH];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES ((g == 0) ? 1 : (g == 1) ? 0 : 3),
        .BASE_ADDR   ((g == 2) ? 32'h0001_0000 : 32'h0000_0000)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ram_ce    (ce[g]),
        .ram_we    (we[g]),
        .ram_sel   (sel[g]),
        .ram_addr  (addr[g]),
        .ram_wdata (wdata[g]),
        .ram_rdata (rdata[g]),
        .ram_ready (ready[g]),
        .ram_err   (err[g])
      );
    end
  endgenerate

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic longint base_of(input int d);
    return (d == 2) ? 64'h1_0000 : 64'h0;
  endfunction

  function automatic bit model_err(input int d, input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] != 2'b00) || (la < base_of(d)) || (la >= base_of(d) + DEPTH * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int d, input int i, input logic [31:0] v);
    case (d)
      0: g_dut[0].u_dut.u_ram.ram_mem[i] = v;
      1: g_dut[1].u_dut.u_ram.ram_mem[i] = v;
      default: g_dut[2].u_dut.u_ram.ram_mem[i] = v;
    endcase
    mem_m[d][i] = v;
  endtask

  // One request from IDLE; called #1 after a posedge, returns #1 after a posedge in IDLE.
  task automatic do_acc(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop);
    bit          e;
    int          idx;
    int          lat;
    logic [31:0] erd;
    e   = model_err(d, a);
    idx = int'((longint'(a) - base_of(d)) / 4) & (DEPTH - 1);
    if (!e && w) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) mem_m[d][idx][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    erd = (e || w) ? 32'h0 : mem_m[d][idx];
    ce[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdata[d] = wd;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready[d]) begin
        lat = k;
        break;
      end
      if (drop) ce[d] = 1'b0;
    end
    ce[d] = 1'b0;
    if (lat == 0) begin
      chk($sformatf("timeout d%0d a%h", d, a), 32'd0, 32'd1);
    end else begin
      chk($sformatf("latency d%0d", d), 32'(lat), 32'(1 + wait_of(d)));
      chk($sformatf("err d%0d a%h", d, a), {31'd0, err[d]}, {31'd0, e});
      chk($sformatf("rdata d%0d a%h", d, a), rdata[d], erd);
      @(posedge clk); #1;
      chk($sformatf("pulse d%0d", d), {31'd0, ready[d]}, 32'd0);
      chk($sformatf("hold d%0d", d), rdata[d], erd);
    end
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    logic [31:0] b;
    b = 32'(base_of(d));
    case ($urandom_range(0, 5))
      0: return b + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(1, 3);
      1: return b + DEPTH * 4 + ($urandom_range(0, 255) << 2);
      2: return b - ($urandom_range(1, 64) << 2);
      default: return b + ($urandom_range(0, 15) << 2);
    endcase
  endfunction

  initial begin
    int pulses;
    int last;
    int cyc;
    int j;
    for (int d = 0; d < ND; d++) begin
      ce[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
      for (int i = 0; i < DEPTH; i++) poke(d, i, $urandom);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk("rst_ready", {31'd0, ready[d]}, 32'd0);
      chk("rst_err", {31'd0, err[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end

    // Basic store/load, byte lanes, errors on the one-wait-state responder.
    do_acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    do_acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    chk("plan_load", mem_m[0][4], 32'hDEADBEEF);
    poke(0, 4, 32'h11223344);
    do_acc(0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0);
    do_acc(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
    do_acc(0, 1'b0, 4'hF, 32'h12, 32'h0, 1'b0);
    do_acc(0, 1'b1, 4'hF, 32'h2000, 32'hCAFEF00D, 1'b0);
    do_acc(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
    do_acc(0, 1'b1, 4'hF, 32'h30, 32'h12345678, 1'b0);
    do_acc(0, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, 1'b0);
    do_acc(0, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0);

    // Reset while a store sits in WAIT: no response, no write.
    ce[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF; addr[0] = 32'h20; wdata[0] = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1; ce[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (ready[0]) pulses++;
      @(posedge clk); #1;
    end
    chk("rst_no_pulse", 32'(pulses), 32'd0);
    chk("rst_rdata_clr", rdata[0], 32'd0);
    do_acc(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);

    // Zero wait states with ce held: three loads, ready every second cycle.
    ce[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; addr[1] = 32'h0;
    j = 0; cyc = 0; last = 0;
    for (int k = 0; k < 30 && j < 3; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (ready[1]) begin
        chk($sformatf("b2b_data%0d", j), rdata[1], mem_m[1][j]);
        chk($sformatf("b2b_gap%0d", j), 32'(cyc - last), (j == 0) ? 32'd1 : 32'd2);
        last = cyc;
        j++;
        addr[1] = 32'(j * 4);
        if (j == 3) ce[1] = 1'b0;
      end
    end
    ce[1] = 1'b0;
    chk("b2b_count", 32'(j), 32'd3);
    @(posedge clk); #1;

    // Randomized mix on all three responders, including dropped ce.
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 60; n++) begin
        do_acc(d, 1'($urandom_range(0, 1)), 4'($urandom), rand_addr(d), $urandom,
               ($urandom_range(0, 7) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
